// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I core.
// Sequences fetch / decode / execute / memory / writeback over a shared
// memory port and a shared ALU, drives every datapath select and write
// enable, and keeps a count of retired instructions.
module multicycle_ctrl #(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [6:0]           op_code_i,
    input  logic [2:0]           funct3_i,
    input  logic                 zero_i,
    input  logic                 mem_ready_i,
    output logic                 pc_wr_o,
    output logic                 ir_wr_o,
    output logic                 adr_src_o,
    output logic                 mem_wr_o,
    output logic                 reg_wr_o,
    output logic [1:0]           result_src_o,
    output logic [1:0]           alu_src_a_o,
    output logic [1:0]           alu_src_b_o,
    output logic [1:0]           alu_op_o,
    output logic                 branch_o,
    output logic                 illegal_o,
    output logic                 retire_o,
    output logic [INSTRET_W-1:0] instret_o,
    output logic [3:0]           state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_e;

    // Major opcodes recognised in DECODE
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Branch funct3 encodings
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    // Datapath select encodings
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] A_PC       = 2'b00;
    localparam logic [1:0] A_OLDPC    = 2'b01;
    localparam logic [1:0] A_RS1      = 2'b10;
    localparam logic [1:0] B_RS2      = 2'b00;
    localparam logic [1:0] B_IMM      = 2'b01;
    localparam logic [1:0] B_FOUR     = 2'b10;
    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;

    localparam logic [INSTRET_W-1:0] INSTRET_ONE = INSTRET_W'(1);

    state_e               state_q;
    state_e               state_d;
    logic [INSTRET_W-1:0] instret_q;
    logic [INSTRET_W-1:0] instret_d;
    logic                 retire_s;

    // Conditional branch decision; only BEQ/BNE are supported, any other
    // funct3 leaves the PC alone.
    function automatic logic branch_taken(input logic [2:0] f3, input logic zero);
        logic taken;
        case (f3)
            F3_BEQ:  taken = zero;
            F3_BNE:  taken = ~zero;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    // State and retired-instruction counter registers; reset wins over everything
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    // Next-state sequencing
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: begin
                if (mem_ready_i) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                case (op_code_i)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_JAL:            state_d = S_JAL;
                    OP_BRANCH:         state_d = S_BEQ;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                if (op_code_i == OP_LOAD) begin
                    state_d = S_MEMREAD;
                end else begin
                    state_d = S_MEMWRITE;
                end
            end
            S_MEMREAD: begin
                if (mem_ready_i) begin
                    state_d = S_MEMWB;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMWB: state_d = S_FETCH;
            S_MEMWRITE: begin
                if (mem_ready_i) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEMWRITE;
                end
            end
            S_EXECR: state_d = S_ALUWB;
            S_EXECI: state_d = S_ALUWB;
            S_ALUWB: state_d = S_FETCH;
            // JAL retires through ALUWB, which writes PC+4 into rd
            S_JAL:   state_d = S_ALUWB;
            S_BEQ:   state_d = S_FETCH;
            // Only reset leaves the trap state
            S_TRAP:  state_d = S_TRAP;
            // Unused encodings recover to FETCH
            default: state_d = S_FETCH;
        endcase
    end

    // Instruction completion: the cycle that hands control back to FETCH
    always_comb begin
        retire_s = 1'b0;
        case (state_q)
            S_MEMWB:    retire_s = 1'b1;
            S_MEMWRITE: retire_s = mem_ready_i;
            S_ALUWB:    retire_s = 1'b1;
            S_BEQ:      retire_s = 1'b1;
            default:    retire_s = 1'b0;
        endcase
    end

    // Counter next value; wraps naturally at 2^INSTRET_W
    always_comb begin
        if (retire_s) begin
            instret_d = instret_q + INSTRET_ONE;
        end else begin
            instret_d = instret_q;
        end
    end

    // Moore datapath controls, plus the few enables gated by live inputs
    always_comb begin
        pc_wr_o      = 1'b0;
        ir_wr_o      = 1'b0;
        adr_src_o    = 1'b0;
        mem_wr_o     = 1'b0;
        reg_wr_o     = 1'b0;
        result_src_o = RES_ALUOUT;
        alu_src_a_o  = A_PC;
        alu_src_b_o  = B_RS2;
        alu_op_o     = ALU_ADD;
        branch_o     = 1'b0;
        illegal_o    = 1'b0;
        case (state_q)
            S_FETCH: begin
                // PC+4 goes straight to the PC while IR/old-PC capture the fetch
                alu_src_a_o  = A_PC;
                alu_src_b_o  = B_FOUR;
                alu_op_o     = ALU_ADD;
                result_src_o = RES_ALU;
                ir_wr_o      = mem_ready_i;
                pc_wr_o      = mem_ready_i;
            end
            S_DECODE: begin
                // Precompute the branch target old PC + imm into ALUOut
                alu_src_a_o = A_OLDPC;
                alu_src_b_o = B_IMM;
                alu_op_o    = ALU_ADD;
            end
            S_MEMADR: begin
                alu_src_a_o = A_RS1;
                alu_src_b_o = B_IMM;
                alu_op_o    = ALU_ADD;
            end
            S_MEMREAD: begin
                adr_src_o    = 1'b1;
                result_src_o = RES_ALUOUT;
            end
            S_MEMWB: begin
                result_src_o = RES_MEM;
                reg_wr_o     = 1'b1;
            end
            S_MEMWRITE: begin
                // Strobe stays up for the whole wait
                adr_src_o = 1'b1;
                mem_wr_o  = 1'b1;
            end
            S_EXECR: begin
                alu_src_a_o = A_RS1;
                alu_src_b_o = B_RS2;
                alu_op_o    = ALU_FUNCT;
            end
            S_EXECI: begin
                alu_src_a_o = A_RS1;
                alu_src_b_o = B_IMM;
                alu_op_o    = ALU_FUNCT;
            end
            S_ALUWB: begin
                result_src_o = RES_ALUOUT;
                reg_wr_o     = 1'b1;
            end
            S_JAL: begin
                // Jump target (from DECODE) into PC; old PC + 4 into ALUOut
                alu_src_a_o  = A_OLDPC;
                alu_src_b_o  = B_FOUR;
                alu_op_o     = ALU_ADD;
                result_src_o = RES_ALUOUT;
                pc_wr_o      = 1'b1;
            end
            S_BEQ: begin
                alu_src_a_o  = A_RS1;
                alu_src_b_o  = B_RS2;
                alu_op_o     = ALU_SUB;
                result_src_o = RES_ALUOUT;
                branch_o     = 1'b1;
                pc_wr_o      = branch_taken(funct3_i, zero_i);
            end
            S_TRAP: begin
                illegal_o = 1'b1;
            end
            default: begin
                illegal_o = 1'b0;
            end
        endcase
    end

    // A retire in the same cycle as reset is cancelled along with the transition
    always_comb begin
        if (rst_i) begin
            retire_o = 1'b0;
        end else begin
            retire_o = retire_s;
        end
    end

    assign instret_o = instret_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl, plus hand-written
// sequences for instruction latency and trap/reset behaviour.
module tb_multicycle_ctrl;

    localparam int IW = 3;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic          clk;
    logic          rst;
    logic [6:0]    op_code;
    logic [2:0]    funct3;
    logic          zero;
    logic          rdy;
    logic          pc_wr;
    logic          ir_wr;
    logic          adr_src;
    logic          mem_wr;
    logic          reg_wr;
    logic [1:0]    result_src;
    logic [1:0]    alu_src_a;
    logic [1:0]    alu_src_b;
    logic [1:0]    alu_op;
    logic          branch;
    logic          illegal;
    logic          retire;
    logic [IW-1:0] instret;
    logic [3:0]    state;

    int n_vec;
    int n_err;

    typedef struct {
        logic          rst;
        logic [6:0]    op;
        logic [2:0]    f3;
        logic          zero;
        logic          rdy;
        logic [3:0]    st;
        logic          pcw;
        logic          irw;
        logic          adr;
        logic          mwr;
        logic          rwr;
        logic [1:0]    rsrc;
        logic [1:0]    a;
        logic [1:0]    b;
        logic [1:0]    aop;
        logic          br;
        logic          ill;
        logic          ret;
        logic [IW-1:0] cnt;
    } vec_t;

    vec_t vq[$];

    multicycle_ctrl #(.INSTRET_W(IW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .op_code_i    (op_code),
        .funct3_i     (funct3),
        .zero_i       (zero),
        .mem_ready_i  (rdy),
        .pc_wr_o      (pc_wr),
        .ir_wr_o      (ir_wr),
        .adr_src_o    (adr_src),
        .mem_wr_o     (mem_wr),
        .reg_wr_o     (reg_wr),
        .result_src_o (result_src),
        .alu_src_a_o  (alu_src_a),
        .alu_src_b_o  (alu_src_b),
        .alu_op_o     (alu_op),
        .branch_o     (branch),
        .illegal_o    (illegal),
        .retire_o     (retire),
        .instret_o    (instret),
        .state_o      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Cycles from entering FETCH until retire_o, with memory always ready
    task automatic latency(input logic [6:0] op, input int exp_cyc, input string name);
        int cyc;
        bit seen;
        cyc  = 0;
        seen = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; rdy = 1'b1; op_code = op; funct3 = 3'b000; zero = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            cyc++;
            if (retire) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        n_vec++;
        if (!seen || cyc != exp_cyc) begin
            n_err++;
            $display("FAIL latency_%s: got %0d cycles (retired=%0d), expected %0d", name, cyc, seen, exp_cyc);
        end
    endtask

    initial begin
        logic [22:0] act;
        logic [22:0] exp;
        vec_t        v;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1; op_code = OP_R; funct3 = 3'b000; zero = 1'b0; rdy = 1'b0;

        // rst op f3 zero rdy | st pcw irw adr mwr rwr rsrc a b aop br ill ret cnt
        // R-type with memory ready: 0,1,6,7
        vq.push_back('{1'b1, OP_R, 3'b000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0});
        vq.push_back('{1'b0, OP_R, 3'b000, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0});
        vq.push_back('{1'b0, OP_R, 3'b000, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0});
        vq.push_back('{1'b0, OP_R, 3'b000, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 3'd0});
        vq.push_back('{1'b0, OP_R, 3'b000, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 3'd0});
        // lw with two wait cycles in MEMREAD
        vq.push_back('{1'b0, OP_LW, 3'b000, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 3'd1});
        vq.push_back('{1'b0, OP_LW, 3'b000, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 3'd1});
        vq.push_back('{1'b0, OP_LW, 3'b000, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 3'd1});
        vq.push_back('{1'b0, OP_LW, 3'b000, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 3'd1});
        vq.push_back('{1'b0, OP_LW, 3'b000, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 3'd1});
        vq.push_back('{1'b0, OP_LW, 3'b000, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 3'd1});
        vq.push_back('{1'b0, OP_LW, 3'b000, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 3'd1});
        // I-type
        vq.push_back('{1'b0, OP_I, 3'b000, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 3'd2});
        vq.push_back('{1'b0, OP_I, 3'b000, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 3'd2});
        vq.push_back('{1'b0, OP_I, 3'b000, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 3'd2});
        vq.push_back('{1'b0, OP_I, 3'b000, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 3'd2});
        // sw with three wait cycles in MEMWRITE
        vq.push_back('{1'b0, OP_SW, 3'b000, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 3'd3});
        vq.push_back('{1'b0, OP_SW, 3'b000, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 3'd3});
        vq.push_back('{1'b0, OP_SW, 3'b000, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 3'd3});
        vq.push_back('{1'b0, OP_SW, 3'b000, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 3'd3});
        vq.push_back('{1'b0, OP_SW, 3'b000, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 3'd3});
        vq.push_back('{1'b0, OP_SW, 3'b000, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 3'd3});
        vq.push_back('{1'b0, OP_SW, 3'b000, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 3'd3});
        // jal
        vq.push_back('{1'b0, OP_JAL, 3'b000, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 3'd4});
        vq.push_back('{1'b0, OP_JAL, 3'b000, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 3'd4});
        vq.push_back('{1'b0, OP_JAL, 3'b000, 1'b0, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 3'd4});
        vq.push_back('{1'b0, OP_JAL, 3'b000, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 3'd4});
        // beq taken (f3=000, zero=1)
        vq.push_back('{1'b0, OP_BR, 3'b000, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 3'd5});
        vq.push_back('{1'b0, OP_BR, 3'b000, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 3'd5});
        vq.push_back('{1'b0, OP_BR, 3'b000, 1'b1, 1'b1, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b1, 1'b0, 1'b1, 3'd5});
        // bne not taken (f3=001, zero=1)
        vq.push_back('{1'b0, OP_BR, 3'b001, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 3'd6});
        vq.push_back('{1'b0, OP_BR, 3'b001, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 3'd6});
        vq.push_back('{1'b0, OP_BR, 3'b001, 1'b1, 1'b1, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b1, 1'b0, 1'b1, 3'd6});
        // bne taken (f3=001, zero=0); counter wraps 7 -> 0 on this retire
        vq.push_back('{1'b0, OP_BR, 3'b001, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 3'd7});
        vq.push_back('{1'b0, OP_BR, 3'b001, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 3'd7});
        vq.push_back('{1'b0, OP_BR, 3'b001, 1'b0, 1'b1, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b1, 1'b0, 1'b1, 3'd7});
        // unsupported branch funct3 (010) never writes PC
        vq.push_back('{1'b0, OP_BR, 3'b010, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0});
        vq.push_back('{1'b0, OP_BR, 3'b010, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0});
        vq.push_back('{1'b0, OP_BR, 3'b010, 1'b1, 1'b1, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b1, 1'b0, 1'b1, 3'd0});
        // FETCH wait, then reset while MEMREAD has memory ready
        vq.push_back('{1'b0, OP_LW, 3'b000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 3'd1});
        vq.push_back('{1'b0, OP_LW, 3'b000, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 3'd1});
        vq.push_back('{1'b0, OP_LW, 3'b000, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 3'd1});
        vq.push_back('{1'b0, OP_LW, 3'b000, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 3'd1});
        vq.push_back('{1'b1, OP_LW, 3'b000, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 3'd1});
        vq.push_back('{1'b0, OP_LW, 3'b000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0});
        // R-type retires once, then reset lands in ALUWB: retire suppressed
        vq.push_back('{1'b0, OP_R, 3'b000, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0});
        vq.push_back('{1'b0, OP_R, 3'b000, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0});
        vq.push_back('{1'b0, OP_R, 3'b000, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 3'd0});
        vq.push_back('{1'b0, OP_R, 3'b000, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 3'd0});
        vq.push_back('{1'b0, OP_R, 3'b000, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 3'd1});
        vq.push_back('{1'b0, OP_R, 3'b000, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 3'd1});
        vq.push_back('{1'b0, OP_R, 3'b000, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 3'd1});
        vq.push_back('{1'b1, OP_R, 3'b000, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 3'd1});
        vq.push_back('{1'b0, OP_R, 3'b000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0});
        // illegal opcode traps; inputs are ignored until reset
        vq.push_back('{1'b0, OP_BAD, 3'b000, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0});
        vq.push_back('{1'b0, OP_BAD, 3'b000, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0});
        vq.push_back('{1'b0, OP_BAD, 3'b000, 1'b1, 1'b1, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 3'd0});
        vq.push_back('{1'b0, OP_R, 3'b001, 1'b0, 1'b1, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 3'd0});
        vq.push_back('{1'b0, OP_LW, 3'b000, 1'b0, 1'b0, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 3'd0});
        vq.push_back('{1'b1, OP_LW, 3'b000, 1'b0, 1'b0, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 3'd0});
        vq.push_back('{1'b0, OP_LW, 3'b000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0});

        // Initial reset
        repeat (2) @(posedge clk);

        // Table: drive just after the edge, compare mid-cycle
        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            @(posedge clk); #1;
            rst = v.rst; op_code = v.op; funct3 = v.f3; zero = v.zero; rdy = v.rdy;
            @(negedge clk);
            act = {state, pc_wr, ir_wr, adr_src, mem_wr, reg_wr, result_src, alu_src_a, alu_src_b, alu_op, branch, illegal, retire, instret};
            exp = {v.st, v.pcw, v.irw, v.adr, v.mwr, v.rwr, v.rsrc, v.a, v.b, v.aop, v.br, v.ill, v.ret, v.cnt};
            n_vec++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL vec%0d: got state=%0d bus=%h, expected state=%0d bus=%h", i, state, act, v.st, exp);
            end
        end

        // Latency with memory always ready; counter goes 0 -> 5
        latency(OP_R,   4, "rtype");
        latency(OP_LW,  5, "lw");
        latency(OP_SW,  4, "sw");
        latency(OP_BR,  3, "beq");
        latency(OP_JAL, 4, "jal");

        // Trap held indefinitely under random inputs
        @(posedge clk); #1;
        rst = 1'b0; rdy = 1'b1; op_code = OP_BAD;
        @(posedge clk);
        @(posedge clk); #1;
        for (int c = 0; c < 16; c++) begin
            rdy = 1'($urandom_range(1, 0));
            zero = 1'($urandom_range(1, 0));
            funct3 = 3'($urandom_range(7, 0));
            op_code = 7'($urandom_range(127, 0));
            @(negedge clk);
            n_vec++;
            if (state !== 4'd11 || illegal !== 1'b1 || {pc_wr, ir_wr, mem_wr, reg_wr, retire} !== 5'b00000 || instret !== 3'd5) begin
                n_err++;
                $display("FAIL trap_hold%0d: got state=%0d illegal=%b en=%b instret=%0d, expected 11 1 00000 5", c, state, illegal, {pc_wr, ir_wr, mem_wr, reg_wr, retire}, instret);
            end
            @(posedge clk); #1;
        end

        // Reset pulse leaves the trap and clears the counter
        rst = 1'b1; rdy = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (state !== 4'd0 || instret !== 3'd0 || illegal !== 1'b0) begin
            n_err++;
            $display("FAIL trap_reset: got state=%0d instret=%0d illegal=%b, expected 0 0 0", state, instret, illegal);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
